// File: rtl/multicycle_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_hs
// Brief    : Multicycle CPU control FSM with memory handshake, trap, display
//            and halt classes, plus a retired-instruction counter.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl_hs #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                pc_cond,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                mem_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_src,
    output logic [1:0]          data_src,
    output logic                reg_write,
    output logic                a_src,
    output logic [1:0]          b_src,
    output logic [1:0]          alu_op,
    output logic                display_write,
    output logic                trap,
    output logic                halted,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ADDR   = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEM_WB = 4'd4,
        S_MEMWR  = 4'd5,
        S_R_EXEC = 4'd6,
        S_R_WB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_I_EXEC = 4'd10,
        S_I_WB   = 4'd11,
        S_DISP   = 4'd12,
        S_TRAP   = 4'd13,
        S_HALT   = 4'd14,
        S_BAD    = 4'd15
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_retire;
    logic [2:0]         w_class;
    logic [CNT_W-1:0]   r_retired;
    logic               w_unused_opcode;

    assign w_class         = opcode[OPCODE_W-1 -: 3];
    // Middle opcode bits belong to the datapath, not to sequencing.
    assign w_unused_opcode = ^opcode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_retire      = 1'b0;
        pc_cond       = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        mem_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_src       = 1'b0;
        data_src      = 2'b00;
        reg_write     = 1'b0;
        a_src         = 1'b0;
        b_src         = 2'b00;
        alu_op        = 2'b00;
        display_write = 1'b0;
        trap          = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                b_src    = 2'b01;
                // Strobes fire only on the cycle the fetch completes.
                ir_write = mem_ready & ~reset;
                pc_write = mem_ready & ~reset;
                w_next   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                b_src = 2'b11;
                case (w_class)
                    3'b000:  w_next = S_R_EXEC;
                    3'b100:  w_next = S_I_EXEC;
                    3'b010:  w_next = S_BRANCH;
                    3'b001:  w_next = S_ADDR;
                    3'b111:  w_next = S_JUMP;
                    3'b110:  w_next = S_DISP;
                    3'b011:  w_next = S_HALT;
                    default: w_next = S_TRAP;
                endcase
            end
            S_ADDR: begin
                a_src  = 1'b1;
                b_src  = 2'b10;
                w_next = opcode[0] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_src  = 1'b1;
                mem_read = 1'b1;
                w_next   = mem_ready ? S_MEM_WB : S_MEMRD;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
            end
            S_MEMWR: begin
                mem_src   = 1'b1;
                mem_write = 1'b1;
                w_retire  = mem_ready;
                w_next    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_R_EXEC: begin
                a_src  = 1'b1;
                alu_op = 2'b10;
                w_next = S_R_WB;
            end
            S_R_WB: begin
                reg_src   = 1'b1;
                reg_write = 1'b1;
                data_src  = 2'b01;
                w_retire  = 1'b1;
            end
            S_BRANCH: begin
                a_src    = 1'b1;
                alu_op   = 2'b01;
                pc_cond  = 1'b1;
                pc_src   = 2'b01;
                w_retire = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                w_retire = 1'b1;
            end
            S_I_EXEC: begin
                a_src  = 1'b1;
                b_src  = 2'b10;
                alu_op = 2'b10;
                w_next = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                data_src  = 2'b01;
                w_retire  = 1'b1;
            end
            S_DISP: begin
                display_write = 1'b1;
                w_retire      = 1'b1;
            end
            S_TRAP: begin
                trap     = 1'b1;
                pc_write = 1'b1;
                pc_src   = 2'b11;
            end
            S_HALT: begin
                halted   = 1'b1;
                w_retire = resume;
                w_next   = resume ? S_FETCH : S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_hs
// Brief    : Self-checking bench: instruction-level reference model plus
//            directed literal sequences and randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl_hs;

    localparam int OPCODE_W = 6;
    localparam int CNT_W    = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [OPCODE_W-1:0] opcode = '0;
    logic                mem_ready = 1'b1;
    logic                resume = 1'b0;
    logic                pc_cond, pc_write, mem_src, mem_read, mem_write, ir_write;
    logic                reg_src, reg_write, a_src, display_write, trap, halted;
    logic [1:0]          pc_src, data_src, b_src, alu_op;
    logic [3:0]          state;
    logic [CNT_W-1:0]    retired;

    multicycle_ctrl_hs #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .resume(resume), .pc_cond(pc_cond), .pc_write(pc_write), .pc_src(pc_src),
        .mem_src(mem_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_src(reg_src), .data_src(data_src),
        .reg_write(reg_write), .a_src(a_src), .b_src(b_src), .alu_op(alu_op),
        .display_write(display_write), .trap(trap), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [21:0] dut_vec;
    assign dut_vec = {pc_cond, pc_write, pc_src, mem_src, mem_read, mem_write, ir_write,
                      reg_src, data_src, reg_write, a_src, b_src, alu_op,
                      display_write, trap, halted};

    // Control word each state must present, written straight from the state action table.
    function automatic logic [21:0] exp_out(input int s, input logic mr, input logic rst);
        logic pcc, pcw, ms, mrd, mwr, irw, rs, rw, as, dw, tp, hl;
        logic [1:0] pcs, ds, bs, ao;
        {pcc, pcw, ms, mrd, mwr, irw, rs, rw, as, dw, tp, hl} = '0;
        {pcs, ds, bs, ao} = '0;
        case (s)
            0:  begin mrd = 1; bs = 2'b01; irw = mr & ~rst; pcw = mr & ~rst; end
            1:  bs = 2'b11;
            2:  begin as = 1; bs = 2'b10; end
            3:  begin ms = 1; mrd = 1; end
            4:  rw = 1;
            5:  begin ms = 1; mwr = 1; end
            6:  begin as = 1; ao = 2'b10; end
            7:  begin rs = 1; rw = 1; ds = 2'b01; end
            8:  begin as = 1; ao = 2'b01; pcc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin as = 1; bs = 2'b10; ao = 2'b10; end
            11: begin rw = 1; ds = 2'b01; end
            12: dw = 1;
            13: begin tp = 1; pcw = 1; pcs = 2'b11; end
            14: hl = 1;
            default: ;
        endcase
        return {pcc, pcw, pcs, ms, mrd, mwr, irw, rs, ds, rw, as, bs, ao, dw, tp, hl};
    endfunction

    // Reference model: each instruction is a list of post-decode states; it
    // retires when its last state is left (trap excepted).
    int m_state = 0;
    int m_ret   = 0;
    int plan[$];
    bit started = 0;

    initial begin
        @(posedge clk);
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("state", state, m_state);
            check("outputs", dut_vec, exp_out(m_state, mem_ready, reset));
            check("retired", retired, m_ret);
            if (reset) begin
                m_state = 0;
                m_ret   = 0;
                plan.delete();
            end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
                m_state = m_state;
            end else if (m_state == 14 && !resume) begin
                m_state = m_state;
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                plan.delete();
                case (opcode[OPCODE_W-1 -: 3])
                    3'b000: begin plan.push_back(6);  plan.push_back(7);  end
                    3'b100: begin plan.push_back(10); plan.push_back(11); end
                    3'b010: plan.push_back(8);
                    3'b001: plan.push_back(2);
                    3'b111: plan.push_back(9);
                    3'b110: plan.push_back(12);
                    3'b011: plan.push_back(14);
                    default: plan.push_back(13);
                endcase
                m_state = plan.pop_front();
            end else if (m_state == 2) begin
                if (opcode[0]) plan.push_back(5);
                else begin plan.push_back(3); plan.push_back(4); end
                m_state = plan.pop_front();
            end else if (plan.size() != 0) begin
                m_state = plan.pop_front();
            end else begin
                if (m_state != 13) m_ret = (m_ret + 1) % (1 << CNT_W);
                m_state = 0;
            end
        end
    end

    // Advance one cycle, apply this cycle's inputs, leave time for outputs to settle.
    task automatic step(input logic r, input logic mr, input logic rs);
        @(posedge clk);
        #1;
        reset = r; mem_ready = mr; resume = rs;
        #1;
    endtask

    int exp_j[5] = '{1, 2, 3, 0, 1};

    initial begin
        // Reset held two cycles
        step(1, 1, 0);
        step(1, 1, 0);
        check("rst_state", state, 0);
        check("rst_retired", retired, 0);
        check("rst_pc_write_gated", pc_write, 0);
        check("rst_mem_read", mem_read, 1);

        // R-type: 0,1,6,7,0
        opcode = 6'b000000;
        step(0, 1, 0); check("r_s0", state, 0); check("r_ir_write", ir_write, 1);
        step(0, 1, 0); check("r_s1", state, 1);
        step(0, 1, 0); check("r_s6", state, 6); check("r_no_wb_early", reg_write, 0);
        step(0, 1, 0); check("r_s7", state, 7); check("r_reg_write", reg_write, 1);
        check("r_data_src", data_src, 1);
        step(0, 1, 0); check("r_back_fetch", state, 0); check("r_retired", retired, 1);

        // LW with three MEMRD wait cycles: 8 cycles total
        opcode = 6'b001000;
        step(0, 1, 0); check("lw_s1", state, 1);
        step(0, 1, 0); check("lw_s2", state, 2);
        for (int i = 0; i < 4; i++) begin
            step(0, (i == 3), 0);
            check("lw_memrd", state, 3);
            check("lw_mem_read", mem_read, 1);
            check("lw_mem_src", mem_src, 1);
        end
        step(0, 0, 0); check("lw_s4", state, 4); check("lw_reg_write", reg_write, 1);

        // FETCH wait of two cycles, then a one-cycle strobe
        step(0, 0, 0); check("fw_s0a", state, 0); check("fw_ir_write_a", ir_write, 0);
        check("lw_retired", retired, 2);
        step(0, 0, 0); check("fw_s0b", state, 0); check("fw_pc_write_b", pc_write, 0);
        step(0, 1, 0); check("fw_s0c", state, 0); check("fw_ir_write_c", ir_write, 1);
        check("fw_pc_write_c", pc_write, 1);

        // Illegal opcode: 0,1,13,0 without retire
        opcode = 6'b101000;
        step(0, 1, 0); check("tr_s1", state, 1); check("fw_ir_write_d", ir_write, 0);
        step(0, 1, 0); check("tr_s13", state, 13); check("tr_trap", trap, 1);
        check("tr_pc_write", pc_write, 1); check("tr_pc_src", pc_src, 3);
        step(0, 1, 0); check("tr_s0", state, 0); check("tr_retired", retired, 2);
        check("tr_trap_gone", trap, 0);

        // HALT: six halted cycles, mem_ready toggling ignored
        opcode = 6'b011000;
        step(0, 1, 0); check("h_s1", state, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, i[0], (i == 5));
            check("h_halted", halted, 1);
            check("h_state", state, 14);
        end
        step(0, 1, 0); check("h_fetch", state, 0); check("h_retired", retired, 3);

        // Reset, then five jumps wrapping a 2-bit counter
        step(1, 1, 0);
        step(0, 1, 0); check("j_rst_state", state, 0); check("j_rst_ret", retired, 0);
        opcode = 6'b111000;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0); check("j_s1", state, 1);
            step(0, 1, 0); check("j_s9", state, 9); check("j_pc_src", pc_src, 2);
            step(0, 1, 0); check("j_retired", retired, exp_j[k]);
        end

        // SW aborted by reset during its MEMWR wait
        opcode = 6'b001001;
        step(0, 1, 0); check("sw_s1", state, 1);
        step(0, 1, 0); check("sw_s2", state, 2);
        step(0, 0, 0); check("sw_s5", state, 5); check("sw_mem_write", mem_write, 1);
        step(1, 0, 0); check("sw_wait", state, 5);
        step(0, 0, 0); check("sw_abort_state", state, 0); check("sw_abort_ret", retired, 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            reset     = ($urandom_range(0, 63) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            resume    = ($urandom_range(0, 3) == 0);
            opcode    = OPCODE_W'($urandom);
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
